trap_seq: RTL and testbench

Sequencer for the PowerPC program-interrupt path raised by the trap comparator (`tw`/`twi`). When the execute-stage trap condition fires, it flushes the younger pipeline and stalls fetch. It then writes SRR0/SRR1 through the shared SPR write port, updates MSR and redirects fetch to the trap vector. It sits between the execute-stage trap comparator, the SPR file and the PC/next-PC logic. All buses use big-endian bit numbering, `[0:N-1]`, with bit 0 as MSB.

---
 rtl/trap_seq_pkg.sv | 26 ++
 rtl/trap_seq.sv | 142 ++++++++++++++
 tb/tb_trap_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_seq_pkg.sv
// trap_seq_pkg: shared definitions for the program-interrupt (trap) sequencer.
//   - FSM state encoding (trapSeq_*), trapSeq_WIDTH
//   - SPR numbers for SRR0/SRR1
//   - MSR bit indices (big-endian numbering, bit 0 = MSB)
package trap_seq_pkg;

   localparam int trapSeq_WIDTH = 3;

   typedef enum logic [trapSeq_WIDTH-1:0] {
      trapSeq_IDLE     = 3'd0,
      trapSeq_FLUSH    = 3'd1,
      trapSeq_WR_SRR0  = 3'd2,
      trapSeq_WR_SRR1  = 3'd3,
      trapSeq_WR_MSR   = 3'd4,
      trapSeq_REDIRECT = 3'd5
   } trap_state_e;

   localparam logic [0:9] SPR_SRR0 = 10'd26;
   localparam logic [0:9] SPR_SRR1 = 10'd27;

   localparam int MSR_EE = 16;
   localparam int MSR_PR = 17;
   localparam int MSR_IR = 26;
   localparam int MSR_DR = 27;

endpackage

// File: rtl/trap_seq.sv
// trap_seq: program-interrupt sequencer for tw/twi traps.
// On a qualified trap in execute it flushes younger instructions, stalls the
// front end, writes SRR0 (trapping PC) and SRR1 (MSR with the trap flag) via
// the shared SPR write port, writes the masked MSR and redirects fetch.
// All buses use big-endian numbering [0:N-1].
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_valid, trap_hit  execute-stage trap request
//   ex_pc, msr          trapping PC and current MSR (latched on accept)
//   spr_wr_ack          SPR file accepted the current write
//   flush, stall, busy  pipeline control / sequencer status
//   spr_wr_req/addr/data  SPR write request (held until ack)
//   msr_wr, msr_wr_data   MSR write strobe and value
//   npc_redirect, npc     fetch redirect to TRAP_VECTOR
//   trap_cnt            trap counter, only when TRAP_CNT_EN is defined
//
// Optional feature macro: TRAP_CNT_EN (32-bit accepted-trap counter).
module trap_seq
   import trap_seq_pkg::*;
#(
   parameter logic [0:31] TRAP_VECTOR   = 32'h0000_0700,
   parameter int          SRR1_PROG_BIT = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        trap_hit,
   input  logic [0:31] ex_pc,
   input  logic [0:31] msr,
   input  logic        spr_wr_ack,
   output logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        spr_wr_req,
   output logic [0:9]  spr_wr_addr,
   output logic [0:31] spr_wr_data,
   output logic        msr_wr,
   output logic [0:31] msr_wr_data,
   output logic        npc_redirect,
   output logic [0:31] npc
`ifdef TRAP_CNT_EN
   ,
   output logic [0:31] trap_cnt
`endif
);

   trap_state_e state_q, state_d;
   logic [0:31] pc_q, pc_d;
   logic [0:31] msr_q, msr_d;

   // Outputs decode from state_q only; trap_hit only steers state_d.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      msr_d        = msr_q;
      flush        = 1'b0;
      spr_wr_req   = 1'b0;
      spr_wr_addr  = '0;
      spr_wr_data  = '0;
      msr_wr       = 1'b0;
      msr_wr_data  = '0;
      npc_redirect = 1'b0;
      npc          = '0;
      stall        = (state_q != trapSeq_IDLE);
      busy         = (state_q != trapSeq_IDLE);

      case (state_q)
         trapSeq_IDLE: begin
            if (ex_valid && trap_hit) begin
               pc_d    = ex_pc;
               msr_d   = msr;
               state_d = trapSeq_FLUSH;
            end
         end
         trapSeq_FLUSH: begin
            flush   = 1'b1;
            state_d = trapSeq_WR_SRR0;
         end
         trapSeq_WR_SRR0: begin
            spr_wr_req  = 1'b1;
            spr_wr_addr = SPR_SRR0;
            spr_wr_data = pc_q;
            if (spr_wr_ack) state_d = trapSeq_WR_SRR1;
         end
         trapSeq_WR_SRR1: begin
            spr_wr_req                 = 1'b1;
            spr_wr_addr                = SPR_SRR1;
            spr_wr_data                = msr_q;
            spr_wr_data[SRR1_PROG_BIT] = 1'b1;
            if (spr_wr_ack) state_d = trapSeq_WR_MSR;
         end
         trapSeq_WR_MSR: begin
            // Enter supervisor mode with interrupts and translation off.
            msr_wr              = 1'b1;
            msr_wr_data         = msr_q;
            msr_wr_data[MSR_EE] = 1'b0;
            msr_wr_data[MSR_PR] = 1'b0;
            msr_wr_data[MSR_IR] = 1'b0;
            msr_wr_data[MSR_DR] = 1'b0;
            state_d             = trapSeq_REDIRECT;
         end
         trapSeq_REDIRECT: begin
            npc_redirect = 1'b1;
            npc          = TRAP_VECTOR;
            state_d      = trapSeq_IDLE;
         end
         default: state_d = trapSeq_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= trapSeq_IDLE;
         pc_q    <= '0;
         msr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         msr_q   <= msr_d;
      end
   end

`ifdef TRAP_CNT_EN
   logic [0:31] trap_cnt_q, trap_cnt_d;

   // Counts accepted traps (IDLE -> FLUSH); wraps naturally at 2^32.
   always_comb begin
      trap_cnt_d = trap_cnt_q;
      if (state_q == trapSeq_IDLE && state_d == trapSeq_FLUSH)
         trap_cnt_d = trap_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) trap_cnt_q <= '0;
      else     trap_cnt_q <= trap_cnt_d;
   end

   assign trap_cnt = trap_cnt_q;
`endif

endmodule

// File: tb/tb_trap_seq.sv
module tb_trap_seq;

   logic        clk = 1'b0;
   logic        rst, ex_valid, trap_hit, spr_wr_ack;
   logic [0:31] ex_pc, msr;
   logic        flush, stall, busy, spr_wr_req, msr_wr, npc_redirect;
   logic [0:9]  spr_wr_addr;
   logic [0:31] spr_wr_data, msr_wr_data, npc;
`ifdef TRAP_CNT_EN
   logic [0:31] trap_cnt;
`endif

   trap_seq dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .trap_hit(trap_hit),
      .ex_pc(ex_pc), .msr(msr), .spr_wr_ack(spr_wr_ack),
      .flush(flush), .stall(stall), .busy(busy),
      .spr_wr_req(spr_wr_req), .spr_wr_addr(spr_wr_addr), .spr_wr_data(spr_wr_data),
      .msr_wr(msr_wr), .msr_wr_data(msr_wr_data),
      .npc_redirect(npc_redirect), .npc(npc)
`ifdef TRAP_CNT_EN
      , .trap_cnt(trap_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl, st, req;
      logic [9:0]  addr;
      logic [31:0] data;
      logic        mw;
      logic [31:0] md;
      logic        rd;
      logic [31:0] npc;
   } out_t;

   typedef struct {
      logic        rst, ev, th;
      logic [31:0] pc, msr;
      logic        ack;
      out_t        e;
   } vec_t;

   // Reference model: ordered list of pending actions of the interrupt.
   typedef struct { int k; logic [31:0] d; } act_t;  // 1 flush 2 srr0 3 srr1 4 msr 5 redirect
   act_t mq[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   function automatic out_t o_zero();
      out_t o;
      o.fl = 0; o.st = 0; o.req = 0; o.addr = 0; o.data = 0;
      o.mw = 0; o.md = 0; o.rd = 0; o.npc = 0;
      return o;
   endfunction

   function automatic out_t o_of(input int k, input logic [31:0] d);
      out_t o = o_zero();
      if (k != 0) o.st = 1;
      case (k)
         1: o.fl = 1;
         2: begin o.req = 1; o.addr = 10'd26; o.data = d; end
         3: begin o.req = 1; o.addr = 10'd27; o.data = d; end
         4: begin o.mw = 1; o.md = d; end
         5: begin o.rd = 1; o.npc = d; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic vec_t mk(input logic r, ev, th, input logic [31:0] pc, m,
                               input logic ack, input out_t e);
      vec_t v;
      v.rst = r; v.ev = ev; v.th = th; v.pc = pc; v.msr = m; v.ack = ack; v.e = e;
      return v;
   endfunction

   // Big-endian bit b of a 32-bit word has weight 2**(31-b).
   function automatic logic [31:0] be_bit(input int b);
      return 32'h1 << (31 - b);
   endfunction

   function automatic out_t model_out();
      if (mq.size() == 0) return o_zero();
      return o_of(mq[0].k, mq[0].d);
   endfunction

   task automatic model_step();
      act_t a;
      if (rst) mq.delete();
      else if (mq.size() == 0) begin
         if (ex_valid && trap_hit) begin
            a.k = 1; a.d = 0;                                  mq.push_back(a);
            a.k = 2; a.d = ex_pc;                              mq.push_back(a);
            a.k = 3; a.d = msr | be_bit(14);                   mq.push_back(a);
            a.k = 4; a.d = msr & ~(be_bit(16) | be_bit(17) | be_bit(26) | be_bit(27));
                                                               mq.push_back(a);
            a.k = 5; a.d = 32'h0000_0700;                      mq.push_back(a);
         end
      end else if (!((mq[0].k == 2 || mq[0].k == 3) && !spr_wr_ack))
         void'(mq.pop_front());
   endtask

   function automatic out_t sample();
      out_t o;
      o.fl = flush; o.st = stall; o.req = spr_wr_req; o.addr = spr_wr_addr;
      o.data = spr_wr_data; o.mw = msr_wr; o.md = msr_wr_data;
      o.rd = npc_redirect; o.npc = npc;
      return o;
   endfunction

   task automatic cmp(input string t, input out_t a, input out_t e);
      chk({t, ".flush"}, a.fl, e.fl);
      chk({t, ".stall"}, a.st, e.st);
      chk({t, ".busy"}, busy, e.st);
      chk({t, ".req"}, a.req, e.req);
      chk({t, ".addr"}, a.addr, e.addr);
      chk({t, ".data"}, a.data, e.data);
      chk({t, ".msr_wr"}, a.mw, e.mw);
      chk({t, ".msr_data"}, a.md, e.md);
      chk({t, ".redirect"}, a.rd, e.rd);
      chk({t, ".npc"}, a.npc, e.npc);
   endtask

   // One clock: model advances on the same edge as the DUT, compare 1 time unit later.
   task automatic cyc(input string t);
      @(posedge clk);
      model_step();
      #1;
      cmp(t, sample(), model_out());
   endtask

   task automatic drive(input logic r, ev, th, input logic [31:0] pc, m, input logic ack);
      rst = r; ex_valid = ev; trap_hit = th; ex_pc = pc; msr = m; spr_wr_ack = ack;
   endtask

   vec_t tbl[$];
   int flushes, srr0s, mws, rds, first_fl, second_fl;

   initial begin
      drive(1, 0, 0, 0, 0, 0);

      // ---------------- table-driven vectors ----------------
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, o_zero()));
      tbl.push_back(mk(0, 1, 1, 32'h0000_1234, 32'h0000_C030, 1, o_of(1, 0)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(2, 32'h0000_1234)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(3, 32'h0002_C030)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(4, 32'h0000_0000)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(5, 32'h0000_0700)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_zero()));
      tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, o_of(1, 0)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(2, 32'hFFFF_FFFC)));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, o_of(2, 32'hFFFF_FFFC)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(3, 32'hFFFF_FFFF)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, o_of(4, 32'hFFFF_3FCF)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o_of(5, 32'h0000_0700)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o_zero()));
      tbl.push_back(mk(0, 1, 0, 32'h1, 32'h1, 1, o_zero()));
      tbl.push_back(mk(0, 0, 1, 32'h1, 32'h1, 1, o_zero()));
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].ev, tbl[i].th, tbl[i].pc, tbl[i].msr, tbl[i].ack);
         @(posedge clk);
         model_step();
         #1;
         cmp($sformatf("tbl%0d", i), sample(), tbl[i].e);
      end

      // ---------------- delayed ack: 3 low cycles per SRR write ----------------
      drive(1, 0, 0, 0, 0, 0); cyc("dly_rst");
      drive(0, 1, 1, 32'hABCD_0010, 32'h0000_8000, 0); cyc("dly0");
      drive(0, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 12; c++) begin
         spr_wr_ack = (c == 5 || c == 9);
         chk($sformatf("dly_redirect_c%0d", c), npc_redirect, (c == 11));
         if (c >= 2 && c <= 5) begin
            chk("dly_srr0_addr", spr_wr_addr, 10'd26);
            chk("dly_srr0_data", spr_wr_data, 32'hABCD_0010);
         end
         if (c >= 6 && c <= 9) begin
            chk("dly_srr1_addr", spr_wr_addr, 10'd27);
            chk("dly_srr1_data", spr_wr_data, 32'h0002_8000);
         end
         cyc($sformatf("dly%0d", c));
      end

      // ---------------- busy masking ----------------
      drive(1, 0, 0, 0, 0, 1); cyc("bm_rst");
      drive(0, 1, 1, 32'h0000_4000, 32'h0000_0000, 1); cyc("bm0");
      flushes = 0; srr0s = 0;
      for (int c = 1; c <= 10; c++) begin
         ex_valid = (c >= 2 && c <= 4); trap_hit = ex_valid;
         if (flush) flushes++;
         if (spr_wr_req && spr_wr_addr == 10'd26) srr0s++;
         cyc($sformatf("bm%0d", c));
      end
      chk("bm_flush_count", flushes, 1);
      chk("bm_srr0_count", srr0s, 1);

      // ---------------- reset mid-sequence in WR_SRR1 ----------------
      drive(1, 0, 0, 0, 0, 1); cyc("rm_rst");
      drive(0, 1, 1, 32'h0000_2000, 32'h0000_C000, 1); cyc("rm0");
      drive(0, 0, 0, 0, 0, 1); cyc("rm1");
      cyc("rm2");
      chk("rm_in_srr1", spr_wr_addr, 10'd27);
      spr_wr_ack = 0; rst = 1; cyc("rm3");
      cmp("rm_zero", sample(), o_zero());
      rst = 0; spr_wr_ack = 1; mws = 0; rds = 0;
      for (int c = 0; c < 8; c++) begin
         cyc("rm_after");
         if (msr_wr) mws++;
         if (npc_redirect) rds++;
      end
      chk("rm_no_msr_wr", mws, 0);
      chk("rm_no_redirect", rds, 0);

      // ---------------- back-to-back traps ----------------
      drive(1, 0, 0, 0, 0, 1); cyc("bb_rst");
      drive(0, 1, 1, 32'h0000_AAA0, 32'h0000_0010, 1); cyc("bb0");
      ex_pc = 32'h0000_BBB0;
      first_fl = -1; second_fl = -1;
      for (int c = 1; c <= 9; c++) begin
         if (flush) begin
            if (first_fl < 0) first_fl = c;
            else if (second_fl < 0) second_fl = c;
         end
         if (c == 8) chk("bb_second_srr0", spr_wr_data, 32'h0000_BBB0);
         cyc($sformatf("bb%0d", c));
      end
      chk("bb_first_flush", first_fl, 1);
      chk("bb_second_flush", second_fl, 7);

`ifdef TRAP_CNT_EN
      // ---------------- counter wrap ----------------
      drive(0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 12; c++) cyc("cw_drain");
      force dut.trap_cnt_q = 32'hFFFF_FFFF;
      cyc("cw_force");
      release dut.trap_cnt_q;
      chk("cw_preset", trap_cnt, 32'hFFFF_FFFF);
      drive(0, 1, 1, 32'h10, 32'h0, 1); cyc("cw_trap");
      chk("cw_wrap", trap_cnt, 32'h0);
      drive(0, 0, 0, 0, 0, 1);
`endif

      // ---------------- randomized against model ----------------
      drive(1, 0, 0, 0, 0, 0); cyc("rnd_rst");
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 63) == 0);
         ex_valid   = $urandom_range(0, 1);
         trap_hit   = $urandom_range(0, 1);
         ex_pc      = $urandom;
         msr        = $urandom;
         spr_wr_ack = $urandom_range(0, 1);
         cyc("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
